secded_mem_scrubber: RTL and testbench
======================================

Name: secded_mem_scrubber

Overview:
- Parametrised SECDED-protected register-file memory: encodes on write, decodes and corrects on read, and writes corrected data back on single-bit errors.
- Background scrubber walks every address at a programmable interval, fixing single-bit errors before they accumulate into double-bit errors.
- Error-injection port and saturating error counters support fault testing.
- Sits between a host request port and the ECC-protected storage; successor to the combinational Hamming SECDED encode/decode path.

Parameters:
- DATA_W, 32, data word width.
- DEPTH, 16, number of words (>=2).
- ADDR_W, $clog2(DEPTH), address width.
- P, smallest integer with 2**P >= DATA_W+P+1 (6 for DATA_W=32), Hamming parity bit count.
- CW, DATA_W+P+1, stored codeword width (39 for DATA_W=32).
- SCRUB_INTERVAL, 256, idle cycles between scrub accesses (>=2).
- CNT_W, 16, error counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  host request valid.
- req_ready_o  out  1  host request accepted when valid&ready.
- req_we_i  in  1  1=write, 0=read.
- req_addr_i  in  ADDR_W  word address.
- req_wdata_i  in  DATA_W  write data.
- inj_flip_i  in  CW  XOR mask applied to the encoded codeword on host writes only.
- rsp_valid_o  out  1  one-cycle read response pulse.
- rsp_rdata_o  out  DATA_W  corrected read data.
- rsp_sb_err_o  out  1  single-bit error corrected (valid with rsp_valid_o).
- rsp_db_err_o  out  1  uncorrectable error (valid with rsp_valid_o).
- scrub_en_i  in  1  enables the scrubber.
- scrub_busy_o  out  1  high while the FSM is in a scrub state.
- clr_cnt_i  in  1  synchronous clear of both counters.
- sb_cnt_o  out  CNT_W  saturating count of corrected errors.
- db_cnt_o  out  CNT_W  saturating count of uncorrectable errors.

Behaviour:
- Reset state: FSM IDLE, array all-zero (a valid codeword), scrub pointer 0, scrub timer 0, counters 0, all response outputs 0.
- Codeword layout: bit 0 = overall even parity; bits 1..CW-1 Hamming code with parity at power-of-two positions and data in the remaining positions, LSB first, ascending.
- Decode rules:
  - Overall parity OK and syndrome 0: clean.
  - Overall parity bad and syndrome 0: bit 0 flipped; correctable.
  - Overall parity bad and syndrome 1..CW-1: flip that bit; correctable.
  - Overall parity OK and syndrome non-zero: double-bit error.
  - Overall parity bad and syndrome >= CW: treated as double-bit error.
- FSM states: IDLE, RD, SCRUB_RD, SCRUB_CHK.
- req_ready_o is 1 only in IDLE with no scrub start in that cycle; host requests have priority over scrub starts.
- Write accepted at edge T: array[addr] <= enc(wdata) ^ inj_flip_i at T. FSM stays IDLE. No response. A read of the same address accepted at T+1 sees the new data.
- Read accepted at edge T:
  - Codeword is captured at T and the FSM enters RD.
  - At edge T+1 the decode result is registered, rsp_valid_o is high for the cycle after T+1, and the FSM returns to IDLE (ready again in that cycle).
  - Correctable error: the corrected codeword is written back at T+1, rsp_sb_err_o=1, and sb_cnt increments.
  - Double-bit error: raw data bits are returned, rsp_db_err_o=1, db_cnt increments, and there is no write-back.
- Scrub timer:
  - Increments each cycle in IDLE while scrub_en_i=1 and saturates at SCRUB_INTERVAL-1.
  - At saturation with no host request that cycle: enter SCRUB_RD, reset the timer, and capture array[ptr].
  - Next edge: SCRUB_CHK applies the decode rules. Correctable errors are written back and sb_cnt increments; double-bit errors increment db_cnt only.
  - The pointer then advances, wrapping DEPTH-1 -> 0, and the FSM returns to IDLE.
  - Scrub accesses never assert rsp_valid_o.
- scrub_en_i deasserted: the timer holds; an in-progress scrub completes.
- Counters saturate at all-ones. clr_cnt_i takes priority over a simultaneous increment.
- Reset asserted mid-RD or mid-scrub: the operation aborts, no response is issued, and everything returns to the reset state.

Test Plan:
- Reset, then read addr 5 -> rsp_valid_o 2 cycles after acceptance, rdata 0x00000000, no error flags.
- Write 0xDEADBEEF to addr 3 with inj 0, then read addr 3 -> rdata 0xDEADBEEF, sb=0, db=0, counters 0.
- Write 0xA5A5A5A5 to addr 7 with inj_flip bit 10 -> read returns 0xA5A5A5A5, sb=1, sb_cnt=1. A second read is clean and sb_cnt stays 1 (write-back verified).
- Write 0x12345678 to addr 1 with inj bits 3 and 20 -> db=1, db_cnt=1. A repeat read gives db=1 again, db_cnt=2. Then pulse clr_cnt_i -> both counters 0.
- DEPTH=4, SCRUB_INTERVAL=4: inject a single-bit error at addr 2, set scrub_en_i=1, stay idle for 40 cycles -> sb_cnt=1, scrub_busy_o pulses seen, and a later host read of addr 2 is clean.
- CNT_W=2: five correctable reads -> sb_cnt stays 3. Assert rst_i during RD -> no rsp_valid_o, all counters 0.

Source files
------------

// File: rtl/secded_mem_scrubber.sv
// ============================================================================
// Module      : secded_mem_scrubber
// Description : SECDED-protected register-file memory with read correction,
//               write-back of corrected words and a background scrubber.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module secded_mem_scrubber #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int P              = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
    parameter int CW             = DATA_W + P + 1,
    parameter int SCRUB_INTERVAL = 256,
    parameter int CNT_W          = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [CW-1:0]     inj_flip_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_sb_err_o,
    output logic              rsp_db_err_o,
    input  logic              scrub_en_i,
    output logic              scrub_busy_o,
    input  logic              clr_cnt_i,
    output logic [CNT_W-1:0]  sb_cnt_o,
    output logic [CNT_W-1:0]  db_cnt_o
);

    localparam int TMR_W = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [TMR_W-1:0] c_tmr_max = TMR_W'(SCRUB_INTERVAL - 1);
    localparam logic [P:0]       c_cw_ext  = (P + 1)'(CW);
    localparam logic [CW-1:0]    c_one     = {{(CW - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RD        = 2'd1,
        S_SCRUB_RD  = 2'd2,
        S_SCRUB_CHK = 2'd3
    } state_t;

    function automatic logic f_pow2(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

    function automatic logic [CW-1:0] f_enc(input logic [DATA_W-1:0] d);
        logic [CW-1:0] cw;
        logic          par;
        int            j;
        cw = '0;
        j  = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if (!f_pow2(pos)) begin
                cw[pos] = d[j];
                j++;
            end
        end
        for (int k = 0; k < P; k++) begin
            par = 1'b0;
            for (int pos = 1; pos < CW; pos++) begin
                if (pos[k]) par = par ^ cw[pos];
            end
            cw[1 << k] = par;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic logic [P-1:0] f_syn(input logic [CW-1:0] cw);
        logic [P-1:0] s;
        s = '0;
        for (int pos = 1; pos < CW; pos++) begin
            if (cw[pos]) s = s ^ pos[P-1:0];
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] f_data(input logic [CW-1:0] cw);
        logic [DATA_W-1:0] d;
        int                j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if (!f_pow2(pos)) begin
                d[j] = cw[pos];
                j++;
            end
        end
        return d;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_mem [DEPTH];
    logic [CW-1:0]       r_cw;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_ptr;
    logic [TMR_W-1:0]    r_timer;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_sb;
    logic                r_rsp_db;
    logic [CNT_W-1:0]    r_sb_cnt;
    logic [CNT_W-1:0]    r_db_cnt;

    logic                w_ready;
    logic                w_busy;
    logic                w_scrub_start;
    logic                w_accept;
    logic [P-1:0]        w_syn;
    logic                w_par_bad;
    logic                w_syn_oob;
    logic                w_is_sb;
    logic                w_is_db;
    logic [CW-1:0]       w_cw_fix;
    logic [DATA_W-1:0]   w_dec_data;
    logic                w_chk;
    logic                w_wb;

    // Host requests win over a scrub start in the same cycle.
    assign w_scrub_start = (r_state == S_IDLE) && scrub_en_i &&
                           (r_timer == c_tmr_max) && !req_valid_i;
    assign w_accept      = req_valid_i && w_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = !w_scrub_start;
                if (req_valid_i && w_ready && !req_we_i) w_state_nxt = S_RD;
                else if (w_scrub_start)                 w_state_nxt = S_SCRUB_RD;
            end
            S_RD:        w_state_nxt = S_IDLE;
            S_SCRUB_RD: begin
                w_busy      = 1'b1;
                w_state_nxt = S_SCRUB_CHK;
            end
            S_SCRUB_CHK: begin
                w_busy      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // A syndrome beyond the codeword with bad parity cannot be a single flip.
    assign w_syn      = f_syn(r_cw);
    assign w_par_bad  = ^r_cw;
    assign w_syn_oob  = {1'b0, w_syn} >= c_cw_ext;
    assign w_is_sb    = w_par_bad && !w_syn_oob;
    assign w_is_db    = (!w_par_bad && (w_syn != '0)) || (w_par_bad && w_syn_oob);
    assign w_cw_fix   = r_cw ^ (c_one << w_syn);
    assign w_dec_data = w_is_sb ? f_data(w_cw_fix) : f_data(r_cw);
    assign w_chk      = (r_state == S_RD) || (r_state == S_SCRUB_CHK);
    assign w_wb       = w_chk && w_is_sb;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_accept && req_we_i) begin
            r_mem[req_addr_i] <= f_enc(req_wdata_i) ^ inj_flip_i;
        end else if (w_wb) begin
            r_mem[r_addr] <= w_cw_fix;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cw    <= '0;
            r_addr  <= '0;
            r_ptr   <= '0;
            r_timer <= '0;
        end else begin
            if (w_accept && !req_we_i) begin
                r_cw   <= r_mem[req_addr_i];
                r_addr <= req_addr_i;
            end else if (w_scrub_start) begin
                r_cw   <= r_mem[r_ptr];
                r_addr <= r_ptr;
            end
            if (w_scrub_start) begin
                r_timer <= '0;
            end else if ((r_state == S_IDLE) && scrub_en_i && (r_timer != c_tmr_max)) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == S_SCRUB_CHK) begin
                r_ptr <= (r_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_sb    <= 1'b0;
            r_rsp_db    <= 1'b0;
        end else begin
            r_rsp_valid <= (r_state == S_RD);
            if (r_state == S_RD) begin
                r_rsp_rdata <= w_dec_data;
                r_rsp_sb    <= w_is_sb;
                r_rsp_db    <= w_is_db;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sb_cnt <= '0;
            r_db_cnt <= '0;
        end else if (clr_cnt_i) begin
            r_sb_cnt <= '0;
            r_db_cnt <= '0;
        end else begin
            if (w_chk && w_is_sb && (r_sb_cnt != '1)) r_sb_cnt <= r_sb_cnt + 1'b1;
            if (w_chk && w_is_db && (r_db_cnt != '1)) r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign req_ready_o  = w_ready;
    assign scrub_busy_o = w_busy;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_rdata_o  = r_rsp_rdata;
    assign rsp_sb_err_o = r_rsp_sb;
    assign rsp_db_err_o = r_rsp_db;
    assign sb_cnt_o     = r_sb_cnt;
    assign db_cnt_o     = r_db_cnt;

endmodule

`default_nettype wire

// File: tb/tb_secded_mem_scrubber.sv
// ============================================================================
// Module      : tb_secded_mem_scrubber
// Description : Scoreboard bench for secded_mem_scrubber with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_secded_mem_scrubber;

    localparam int DW   = 32;
    localparam int DEP  = 8;
    localparam int AW   = 3;
    localparam int SI   = 4;
    localparam int CNTW = 2;
    localparam int CWL  = 39;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [CWL-1:0]  inj_flip;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_sb;
    logic            rsp_db;
    logic            scrub_en;
    logic            scrub_busy;
    logic            clr_cnt;
    logic [CNTW-1:0] sb_cnt;
    logic [CNTW-1:0] db_cnt;

    secded_mem_scrubber #(
        .DATA_W(DW), .DEPTH(DEP), .SCRUB_INTERVAL(SI), .CNT_W(CNTW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .inj_flip_i(inj_flip),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_sb_err_o(rsp_sb), .rsp_db_err_o(rsp_db),
        .scrub_en_i(scrub_en), .scrub_busy_o(scrub_busy),
        .clr_cnt_i(clr_cnt), .sb_cnt_o(sb_cnt), .db_cnt_o(db_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          sb;
        logic          db;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp     = 0;
    int   n_fail    = 0;
    int   busy_seen = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (scrub_busy === 1'b1) busy_seen++;
        if (rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_rsp", {63'b0, rsp_valid}, 64'd0);
            end else begin
                e = q.pop_front();
                check("rsp_rdata", {32'b0, rsp_rdata}, {32'b0, e.data});
                check("rsp_sb",    {63'b0, rsp_sb},    {63'b0, e.sb});
                check("rsp_db",    {63'b0, rsp_db},    {63'b0, e.db});
                check("rsp_cycle", 64'(cyc),           64'(e.cyc));
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) check("ready_timeout", {63'b0, req_ready}, 64'd1);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [CWL-1:0] inj);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; inj_flip = inj;
        wait_ready();
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; inj_flip = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic sb, input logic db);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        wait_ready();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        q.push_back('{data: d, sb: sb, db: db, cyc: cyc + 1});
        repeat (2) @(negedge clk);
    endtask

    task automatic clr();
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; inj_flip = '0; scrub_en = 1'b0; clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("rst_sb_cnt",    {62'b0, sb_cnt},    64'd0);
        check("rst_db_cnt",    {62'b0, db_cnt},    64'd0);
        check("rst_busy",      {63'b0, scrub_busy}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready",    {63'b0, req_ready}, 64'd1);

        rd(3'd5, 32'h0000_0000, 1'b0, 1'b0);

        wr(3'd3, 32'hDEAD_BEEF, '0);
        rd(3'd3, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("clean_sb_cnt", {62'b0, sb_cnt}, 64'd0);
        check("clean_db_cnt", {62'b0, db_cnt}, 64'd0);

        // Codeword bit 10 carries data bit 5; correction restores the word.
        wr(3'd7, 32'hA5A5_A5A5, 39'd1 << 10);
        rd(3'd7, 32'hA5A5_A5A5, 1'b1, 1'b0);
        check("sb_cnt_one", {62'b0, sb_cnt}, 64'd1);
        rd(3'd7, 32'hA5A5_A5A5, 1'b0, 1'b0);
        check("sb_cnt_after_wb", {62'b0, sb_cnt}, 64'd1);

        // Bits 3 and 20 hold data bits 0 and 14: raw data is returned.
        wr(3'd1, 32'h1234_5678, (39'd1 << 3) | (39'd1 << 20));
        rd(3'd1, 32'h1234_1679, 1'b0, 1'b1);
        check("db_cnt_one", {62'b0, db_cnt}, 64'd1);
        rd(3'd1, 32'h1234_1679, 1'b0, 1'b1);
        check("db_cnt_two", {62'b0, db_cnt}, 64'd2);
        clr();
        check("clr_sb_cnt", {62'b0, sb_cnt}, 64'd0);
        check("clr_db_cnt", {62'b0, db_cnt}, 64'd0);

        // Overall parity bit alone, then a triple flip with syndrome 55 >= CW.
        wr(3'd0, 32'hFFFF_FFFF, 39'd1);
        rd(3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wr(3'd6, 32'h0F0F_0F0F, (39'd1 << 38) | (39'd1 << 1) | (39'd1 << 16));
        rd(3'd6, 32'h8F0F_0F0F, 1'b0, 1'b1);
        check("mix_sb_cnt", {62'b0, sb_cnt}, 64'd1);
        check("mix_db_cnt", {62'b0, db_cnt}, 64'd1);

        wr(3'd1, 32'h1111_1111, '0);
        wr(3'd6, 32'h6666_6666, '0);
        wr(3'd2, 32'h55AA_33CC, 39'd1 << 12);
        clr();
        @(negedge clk);
        scrub_en = 1'b1;
        repeat (80) @(negedge clk);
        scrub_en = 1'b0;
        begin
            int t = 0;
            while (scrub_busy && t < 10) begin
                @(negedge clk);
                t++;
            end
        end
        check("scrub_idle",     {63'b0, scrub_busy}, 64'd0);
        check("scrub_sb_cnt",   {62'b0, sb_cnt},     64'd1);
        check("scrub_db_cnt",   {62'b0, db_cnt},     64'd0);
        check("scrub_busy_seen", 64'(busy_seen != 0), 64'd1);
        rd(3'd2, 32'h55AA_33CC, 1'b0, 1'b0);
        check("post_scrub_sb_cnt", {62'b0, sb_cnt}, 64'd1);

        clr();
        for (int i = 0; i < 5; i++) begin
            wr(3'd4, 32'h0BAD_F00D, 39'd1 << 5);
            rd(3'd4, 32'h0BAD_F00D, 1'b1, 1'b0);
            check("sat_sb_cnt", {62'b0, sb_cnt}, (i < 3) ? 64'(i + 1) : 64'd3);
        end

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
        wait_ready();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rd_not_ready", {63'b0, req_ready}, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstrd_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("rstrd_sb_cnt",    {62'b0, sb_cnt},    64'd0);
        check("rstrd_db_cnt",    {62'b0, db_cnt},    64'd0);
        check("rstrd_ready",     {63'b0, req_ready}, 64'd1);
        rd(3'd3, 32'h0000_0000, 1'b0, 1'b0);

        begin
            int t = 0;
            while (q.size() != 0 && t < 20) begin
                @(negedge clk);
                t++;
            end
        end
        if (q.size() != 0) check("pending_rsp", 64'(q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
